// File: rtl/ssd_value_encoder_pkg.sv
// Shared constants and helpers for the seven-segment value encoder:
// segment patterns ({g,f,e,d,c,b,a}, active-low), FSM states, BCD helper.
package ssd_value_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_ENCODE  = 2'd2
    } state_t;

    localparam logic [6:0] SSD_SEG_0     = 7'b1000000;
    localparam logic [6:0] SSD_SEG_1     = 7'b1111001;
    localparam logic [6:0] SSD_SEG_2     = 7'b0100100;
    localparam logic [6:0] SSD_SEG_3     = 7'b0110000;
    localparam logic [6:0] SSD_SEG_4     = 7'b0011001;
    localparam logic [6:0] SSD_SEG_5     = 7'b0010010;
    localparam logic [6:0] SSD_SEG_6     = 7'b0000010;
    localparam logic [6:0] SSD_SEG_7     = 7'b1111000;
    localparam logic [6:0] SSD_SEG_8     = 7'b0000000;
    localparam logic [6:0] SSD_SEG_9     = 7'b0010000;
    localparam logic [6:0] SSD_SEG_A     = 7'b0001000;
    localparam logic [6:0] SSD_SEG_B     = 7'b0000011;
    localparam logic [6:0] SSD_SEG_C     = 7'b1000110;
    localparam logic [6:0] SSD_SEG_D     = 7'b0100001;
    localparam logic [6:0] SSD_SEG_E     = 7'b0000110;
    localparam logic [6:0] SSD_SEG_F     = 7'b0001110;
    localparam logic [6:0] SSD_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SSD_SEG_DASH  = 7'b0111111;

    localparam logic [15:0] SSD_DEC_MAX = 16'd9999;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'h0:    p = SSD_SEG_0;
            4'h1:    p = SSD_SEG_1;
            4'h2:    p = SSD_SEG_2;
            4'h3:    p = SSD_SEG_3;
            4'h4:    p = SSD_SEG_4;
            4'h5:    p = SSD_SEG_5;
            4'h6:    p = SSD_SEG_6;
            4'h7:    p = SSD_SEG_7;
            4'h8:    p = SSD_SEG_8;
            4'h9:    p = SSD_SEG_9;
            4'hA:    p = SSD_SEG_A;
            4'hB:    p = SSD_SEG_B;
            4'hC:    p = SSD_SEG_C;
            4'hD:    p = SSD_SEG_D;
            4'hE:    p = SSD_SEG_E;
            default: p = SSD_SEG_F;
        endcase
        return p;
    endfunction

    function automatic logic [6:0] seg_polarity(input logic [6:0] p, input logic active_low);
        return active_low ? p : ~p;
    endfunction

    // Add-3 correction applied to every BCD digit >= 5 before each shift.
    function automatic logic [15:0] bcd_add3(input logic [15:0] bcd);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/ssd_digit_enc.sv
// One display digit: maps a nibble to its segment pattern, with blank and
// dash overrides, then applies the board's segment polarity.
module ssd_digit_enc
    import ssd_value_encoder_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    logic [6:0] pat;

    always_comb begin
        pat = seg_pattern(digit);
        if (blank) pat = SSD_SEG_BLANK;
        if (dash)  pat = SSD_SEG_DASH;
        seg = seg_polarity(pat, SEG_ACTIVE_LOW != 0);
    end

endmodule

// File: rtl/ssd_value_encoder.sv
// Accepts a 16-bit value, converts it to four decimal (double-dabble) or hex
// digits and holds the registered segment patterns until the next value.
module ssd_value_encoder
    import ssd_value_encoder_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DEC_ITER       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        hex_mode,
    input  logic        blank_lz,
    input  logic        valid,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [6:0]  seg0,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [6:0]  seg3
);

    localparam logic [3:0] LAST_ITER = 4'(DEC_ITER - 1);

    state_t           state_q, state_d;
    logic [15:0]      shift_q, shift_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       iter_q, iter_d;
    logic             hex_q, hex_d;
    logic             blz_q, blz_d;
    logic             ovf_q, ovf_d;
    logic [3:0][6:0]  seg_q, seg_d;
    logic             done_q, done_d;

    logic [31:0]      dd_shift;
    logic [3:0][3:0]  digit;
    logic [3:0]       blank;
    logic [3:0][6:0]  enc_seg;

    // State register plus the registers that reset demands (segments, done).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            seg_q   <= {4{seg_polarity(SSD_SEG_BLANK, SEG_ACTIVE_LOW != 0)}};
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            seg_q   <= seg_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        bcd_q   <= bcd_d;
        iter_q  <= iter_d;
        hex_q   <= hex_d;
        blz_q   <= blz_d;
        ovf_q   <= ovf_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (valid) state_d = (hex_mode || value > SSD_DEC_MAX) ? ST_ENCODE : ST_CONVERT;
            ST_CONVERT: if (iter_q == LAST_ITER) state_d = ST_ENCODE;
            ST_ENCODE:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        iter_d   = iter_q;
        hex_d    = hex_q;
        blz_d    = blz_q;
        ovf_d    = ovf_q;
        seg_d    = seg_q;
        done_d   = 1'b0;
        dd_shift = {bcd_add3(bcd_q), shift_q};
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    shift_d = value;
                    bcd_d   = 16'd0;
                    iter_d  = 4'd0;
                    hex_d   = hex_mode;
                    blz_d   = blank_lz;
                    ovf_d   = !hex_mode && (value > SSD_DEC_MAX);
                end
            end
            ST_CONVERT: begin
                {bcd_d, shift_d} = {dd_shift[30:0], 1'b0};
                iter_d           = iter_q + 4'd1;
            end
            ST_ENCODE: begin
                seg_d  = enc_seg;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // In hex mode the shift register still holds the untouched input value.
    assign digit = hex_q ? shift_q : bcd_q;

    always_comb begin
        blank[3] = blz_q && (digit[3] == 4'd0);
        blank[2] = blank[3] && (digit[2] == 4'd0);
        blank[1] = blank[2] && (digit[1] == 4'd0);
        blank[0] = 1'b0;
    end

    for (genvar k = 0; k < 4; k++) begin : g_dig
        ssd_digit_enc #(
            .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_enc (
            .digit(digit[k]),
            .blank(blank[k]),
            .dash (ovf_q),
            .seg  (enc_seg[k])
        );
    end

    always_comb begin
        ready = (state_q == ST_IDLE);
        busy  = (state_q == ST_CONVERT) || (state_q == ST_ENCODE);
        done  = done_q;
        seg0  = seg_q[0];
        seg1  = seg_q[1];
        seg2  = seg_q[2];
        seg3  = seg_q[3];
    end

endmodule

// File: tb/tb_ssd_value_encoder.sv
// Bench for ssd_value_encoder: reset state, table of decimal/hex vectors,
// random vectors against a digit model, and multi-cycle corner sequences.
module tb_ssd_value_encoder;

    localparam logic [6:0] BLK  = 7'b1111111;
    localparam logic [6:0] DSH  = 7'b0111111;
    localparam logic [6:0] PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        hex_mode;
    logic        blank_lz;
    logic        valid;
    logic        ready, busy, done;
    logic [6:0]  seg0, seg1, seg2, seg3;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] value;
        logic        hex;
        logic        blz;
        logic [27:0] segs;
        int          lat;
    } vec_t;

    typedef struct {
        logic [27:0] segs;
        int          lat;
    } exp_t;

    vec_t vecs [8];
    exp_t exp_q [$];

    ssd_value_encoder #(
        .SEG_ACTIVE_LOW(1),
        .DEC_ITER      (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .hex_mode(hex_mode),
        .blank_lz(blank_lz),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .seg0    (seg0),
        .seg1    (seg1),
        .seg2    (seg2),
        .seg3    (seg3)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [27:0] model(input logic [15:0] v, input logic h, input logic b);
        int          d [4];
        int          t;
        logic        lead;
        logic [6:0]  s [4];
        if (!h && v > 16'd9999) return {4{DSH}};
        t = int'(v);
        for (int k = 0; k < 4; k++) begin
            if (h) d[k] = (t >> (4 * k)) & 15;
            else begin
                d[k] = t % 10;
                t    = t / 10;
            end
            if (h) d[k] = (int'(v) >> (4 * k)) & 15;
        end
        lead = b;
        for (int k = 3; k >= 1; k--) begin
            if (lead && d[k] == 0) s[k] = BLK;
            else begin
                s[k] = PAT[d[k]];
                lead = 1'b0;
            end
        end
        s[0] = PAT[d[0]];
        return {s[3], s[2], s[1], s[0]};
    endfunction

    task automatic send(input logic [15:0] v, input logic h, input logic b);
        value    = v;
        hex_mode = h;
        blank_lz = b;
        valid    = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        int  cnt = 0;
        logic seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (done) seen = 1'b1;
        end
        n = seen ? cnt : -1;
    endtask

    task automatic check_result(input string name, input int n);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got a result with no expectation queued, want queued entry", name);
            return;
        end
        e = exp_q.pop_front();
        chk({name, "_lat"},  n,    e.lat);
        chk({name, "_seg3"}, seg3, {25'd0, e.segs[27:21]});
        chk({name, "_seg2"}, seg2, {25'd0, e.segs[20:14]});
        chk({name, "_seg1"}, seg1, {25'd0, e.segs[13:7]});
        chk({name, "_seg0"}, seg0, {25'd0, e.segs[6:0]});
    endtask

    initial begin
        int          n;
        int          pulses;
        logic [15:0] rv;
        logic        rh, rb;

        vecs[0] = '{16'd1234, 1'b0, 1'b0, {PAT[1], PAT[2], PAT[3], PAT[4]}, 17};
        vecs[1] = '{16'hBEEF, 1'b1, 1'b0, {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}, 1};
        vecs[2] = '{16'd7,    1'b0, 1'b1, {BLK, BLK, BLK, 7'b1111000}, 17};
        vecs[3] = '{16'd7,    1'b0, 1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}, 17};
        vecs[4] = '{16'd0,    1'b0, 1'b1, {BLK, BLK, BLK, 7'b1000000}, 17};
        vecs[5] = '{16'h00A0, 1'b1, 1'b1, {BLK, BLK, 7'b0001000, 7'b1000000}, 1};
        vecs[6] = '{16'd65535, 1'b0, 1'b1, {DSH, DSH, DSH, DSH}, 1};
        vecs[7] = '{16'd9990, 1'b0, 1'b1, {PAT[9], PAT[9], PAT[9], PAT[0]}, 17};

        rst      = 1'b1;
        valid    = 1'b0;
        value    = 16'd0;
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_seg0",  seg0,  BLK);
        chk("rst_seg1",  seg1,  BLK);
        chk("rst_seg2",  seg2,  BLK);
        chk("rst_seg3",  seg3,  BLK);
        chk("rst_ready", ready, 1);
        chk("rst_busy",  busy,  0);
        chk("rst_done",  done,  0);

        // valid held high with a different value while busy must be ignored
        exp_q.push_back('{{PAT[1], PAT[2], PAT[3], PAT[4]}, 17});
        send(16'd1234, 1'b0, 1'b0);
        value    = 16'h5678;
        hex_mode = 1'b1;
        valid    = 1'b1;
        n        = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 10) valid = 1'b0;
            if (done) break;
        end
        if (!done) n = -1;
        check_result("hold_valid", n);

        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{vecs[i].segs, vecs[i].lat});
            send(vecs[i].value, vecs[i].hex, vecs[i].blz);
            wait_done(n);
            check_result($sformatf("vec%0d", i), n);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_pulse", i), done, 0);
        end

        for (int i = 0; i < 6; i++) begin
            rh = (i >= 4);
            rb = 1'($urandom_range(0, 1));
            rv = rh ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 9999));
            exp_q.push_back('{model(rv, rh, rb), rh ? 1 : 17});
            send(rv, rh, rb);
            wait_done(n);
            check_result($sformatf("rnd%0d_%0h", i, rv), n);
        end

        // overflow then 9999 presented in the done cycle
        exp_q.push_back('{{DSH, DSH, DSH, DSH}, 1});
        send(16'd10000, 1'b0, 1'b0);
        wait_done(n);
        check_result("ovf10000", n);
        chk("b2b_ready", ready, 1);
        exp_q.push_back('{{4{PAT[9]}}, 17});
        send(16'd9999, 1'b0, 1'b0);
        wait_done(n);
        check_result("b2b9999", n);

        // reset on the 5th CONVERT edge aborts with no done pulse
        send(16'd4321, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_seg0",  seg0,  BLK);
        chk("abort_seg1",  seg1,  BLK);
        chk("abort_seg2",  seg2,  BLK);
        chk("abort_seg3",  seg3,  BLK);
        chk("abort_ready", ready, 1);
        chk("abort_busy",  busy,  0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) pulses++;
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", pulses, 0);
        chk("abort_seg0_held", seg0, BLK);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssd_value_encoder.md
Name: ssd_value_encoder

Overview:
- Upstream feeder for the four-digit seven-segment display multiplexer.
- Accepts a 16-bit value over a valid/ready handshake.
- Decimal mode: converts the value to BCD with a sequential double-dabble (shift-add-3) engine. Hex mode: takes the nibbles directly.
- Encodes each digit to a segment pattern and holds the four registered patterns on seg0..seg3 (seg0 = rightmost/least significant) until the next accepted value.

Parameters:
- SEG_ACTIVE_LOW, 1: 1 = segment lit when bit is 0 (matches display board, dp driven 1 = off); 0 = inverted patterns.
- DEC_ITER, 16: double-dabble shift iterations; equals the input width and is fixed at 16.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- value  in  16  binary value to display
- hex_mode  in  1  1 = show the value as 4 hex digits; 0 = show it as decimal 0..9999
- blank_lz  in  1  1 = blank leading zeros (seg0 never blanked)
- valid  in  1  value/hex_mode/blank_lz presented
- ready  out  1  high in IDLE only
- busy  out  1  high in CONVERT or ENCODE
- done  out  1  one-cycle pulse when seg0..seg3 have been updated
- seg0, seg1, seg2, seg3  out  7 each  segment patterns {g,f,e,d,c,b,a}

Behaviour:
- Clocking and reset:
  - One clock, clk; reset rst is synchronous and active-high.
  - All state changes on posedge clk.
  - rst has priority over all other events.
  - Reset values: state=IDLE, ready=1, busy=0, done=0, seg0..seg3=BLANK (7'b1111111 when active-low).
- Handshake and capture:
  - Transfer occurs when valid && ready at an edge (T0).
  - At T0 the block latches value, hex_mode and blank_lz.
  - valid while busy is ignored; there is no queueing.
- States and transitions:
  - IDLE -> ENCODE on transfer if hex_mode=1, or if hex_mode=0 and value>9999 (overflow).
  - IDLE -> CONVERT otherwise.
  - CONVERT: 16-bit shift register plus 16-bit BCD register (4 digits), iteration counter 0..15.
    - Each cycle: every BCD digit >=5 gets +3, then {bcd,shift} shifts left by 1.
    - Counter increments; after iteration 15, go to ENCODE.
    - Digit adders are 4-bit; the add-3 rule guarantees no digit exceeds 9 after the shift.
  - ENCODE (one cycle): writes seg0..seg3 and asserts done for the following cycle; -> IDLE.
- Latency from transfer edge T0 to done high:
  - hex or overflow: done high after T1 (2 cycles after valid was sampled).
  - decimal: done high after T17 (16 CONVERT edges + 1 ENCODE edge).
  - ready returns high in the same cycle done is high, so back-to-back transfers are allowed.
- Digit encoding (active-low): 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
  - BLANK = 1111111, DASH = 0111111 (g only).
  - When SEG_ACTIVE_LOW=0, all patterns are bitwise inverted.
- Overflow: decimal mode with value>9999 shows DASH on all four digits; blank_lz is ignored.
- Leading-zero blanking (both modes): digit k (k=3..1) is BLANK if it and all higher digits are zero. Value 0 shows "   0".
- Segment outputs change only at the ENCODE edge, never mid-conversion, so the display shows no glitches.
- Reset mid-operation aborts the conversion and forces the reset values above; no done pulse is issued.

Decomposition:
- Shared header iob_ssd_enc_def.vh holds:
  - segment pattern constants (SSD_SEG_0..F, SSD_SEG_BLANK, SSD_SEG_DASH)
  - state encodings (IDLE, CONVERT, ENCODE)
  - SSD_DEC_MAX = 9999
- One natural sub-module: ssd_digit_enc.
  - Inputs: 4-bit digit, blank, dash. Output: 7-bit pattern.
  - Applies SEG_ACTIVE_LOW.
  - Instantiated four times.

Test Plan:
- Reset, then idle 5 cycles -> seg0..3=1111111, ready=1, busy=0, done=0.
- Decimal 1234, blank_lz=0 -> done exactly 18 cycles after valid sampled; seg3=1111001, seg2=0100100, seg1=0110000, seg0=0011001.
- Hex 0xBEEF -> done 2 cycles after valid; seg3=0000011, seg2=0000110, seg1=0000110, seg0=0001110.
- Decimal 7:
  - blank_lz=1 -> seg3..1=1111111, seg0=1111000.
  - blank_lz=0 -> seg3..1=1000000, seg0=1111000.
  - decimal 0 with blank_lz=1 -> seg0=1000000, others blank.
- Decimal 10000 -> all segs=0111111 after 2 cycles; then decimal 9999 back-to-back in the done cycle -> accepted, all segs=0010000.
- rst pulsed on the 5th CONVERT cycle of value 4321 -> next cycle segs blank, ready=1, no done pulse. valid held during busy is ignored: the latched value is unchanged when checked.
